// File: rtl/spi_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_controller_if
// Description : Bundle of the request/response signals and the 4-wire SPI
//               bus pins of the single-byte SPI controller.
//               master : view used by the controller itself
//               slave  : opposite view (on-chip requester + SPI peripheral)
// Signals     : start, tx_data          - transfer request and byte to send
//               busy, done, rx_data     - status and received byte
//               sck, ss, mosi           - SPI clock, select (active-low), data out
//               miso                    - SPI data in
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_controller_if;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       sck;
    logic       ss;
    logic       mosi;
    logic       miso;

    modport master (
        input  start,
        input  tx_data,
        input  miso,
        output busy,
        output done,
        output rx_data,
        output sck,
        output ss,
        output mosi
    );

    modport slave (
        output start,
        output tx_data,
        output miso,
        input  busy,
        input  done,
        input  rx_data,
        input  sck,
        input  ss,
        input  mosi
    );
endinterface
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : spi_controller
// Description : SPI mode-0 master performing one full-duplex byte per ss
//               assertion. tx_data leaves MSB-first on mosi while miso is
//               collected MSB-first into rx_data. sck runs at
//               clk / (2*CLK_DIV).
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - spi_controller_if.master (start, tx_data, busy, done,
//                        rx_data, sck, ss, mosi, miso)
// Parameters  : CLK_DIV - sck half-period in clk cycles (>= 2)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_controller_if.master        bus
);

    localparam int                 DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    // Half-period index of the final (8th) sck fall inside XFER. The SETUP
    // phase already forms the first half-period, so XFER sees indices 0..14.
    localparam logic [3:0]         EDGE_LAST = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_edge;
    // Bit 7 goes straight to mosi on acceptance, so only the remaining
    // seven bits need to be shifted.
    logic [6:0]       r_tx_sr;
    logic [7:0]       r_rx_sr;
    logic             r_sck;
    logic             r_ss;
    logic             r_mosi;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_rx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_edge    <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_sck     <= 1'b0;
            r_ss      <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rx_data <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_tx_sr <= bus.tx_data[6:0];
                        r_mosi  <= bus.tx_data[7];
                        r_ss    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_div   <= '0;
                        r_edge  <= '0;
                        r_rx_sr <= '0;
                        r_state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        r_sck   <= 1'b1;
                        r_state <= S_XFER;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                S_XFER: begin
                    // miso is captured on the first clk edge of each high
                    // phase; the peripheral only changes it on sck falls.
                    if (r_sck && (r_div == '0)) begin
                        r_rx_sr <= {r_rx_sr[6:0], bus.miso};
                    end
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (r_edge == EDGE_LAST) begin
                            // 8th fall: mosi keeps bit 0 through HOLD.
                            r_sck   <= 1'b0;
                            r_state <= S_HOLD;
                        end else begin
                            r_edge <= r_edge + 4'd1;
                            r_sck  <= ~r_sck;
                            if (r_sck) begin
                                r_mosi  <= r_tx_sr[6];
                                r_tx_sr <= {r_tx_sr[5:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (r_div == DIV_LAST) begin
                        r_div     <= '0;
                        r_ss      <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_rx_data <= r_rx_sr;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sck     = r_sck;
    assign bus.ss      = r_ss;
    assign bus.mosi    = r_mosi;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_controller
// Description : Self-checking bench for spi_controller. Two instances
//               (CLK_DIV=4 with a mode-0 peripheral or loopback, CLK_DIV=2 in
//               loopback) are compared every cycle against a transfer-level
//               model, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_controller_if if4 ();
    spi_controller_if if2 ();

    spi_controller #(.CLK_DIV(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    spi_controller #(.CLK_DIV(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    // ---------------- stimulus and observation arrays ----------------
    logic       start_q [2];
    logic [7:0] tx_q    [2];
    logic       ss_o [2], sck_o [2], mosi_o [2], busy_o [2], done_o [2];
    logic [7:0] rx_o [2];

    assign if4.start   = start_q[0];
    assign if4.tx_data = tx_q[0];
    assign if2.start   = start_q[1];
    assign if2.tx_data = tx_q[1];

    assign ss_o[0] = if4.ss;   assign sck_o[0] = if4.sck;   assign mosi_o[0] = if4.mosi;
    assign busy_o[0] = if4.busy; assign done_o[0] = if4.done; assign rx_o[0] = if4.rx_data;
    assign ss_o[1] = if2.ss;   assign sck_o[1] = if2.sck;   assign mosi_o[1] = if2.mosi;
    assign busy_o[1] = if2.busy; assign done_o[1] = if2.done; assign rx_o[1] = if2.rx_data;

    // ---------------- mode-0 peripheral on instance 0 ----------------
    logic       loop0  = 1'b1;
    logic [7:0] p_byte = 8'h00;
    logic [7:0] p_shift = 8'h00;
    logic [7:0] p_cap   = 8'h00;
    int         p_rises = 0;

    always @(negedge if4.ss) begin
        p_shift = p_byte;
        p_cap   = 8'h00;
        p_rises = 0;
    end
    always @(posedge if4.sck) if (!if4.ss) begin
        p_cap = {p_cap[6:0], if4.mosi};
        p_rises++;
    end
    always @(negedge if4.sck) if (!if4.ss) p_shift = {p_shift[6:0], 1'b0};

    assign if4.miso = if4.ss ? 1'b0 : (loop0 ? if4.mosi : p_shift[7]);
    assign if2.miso = if2.mosi;

    // ---------------- counters ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // ---------------- transfer-level reference model ----------------
    // A transfer accepted at some edge occupies 17*H cycles of ss low; the
    // output pattern is a pure function of the cycle offset q since then.
    int         HV [2] = '{4, 2};
    bit         m_act [2];
    int         m_q   [2];
    logic [7:0] m_tx  [2];
    logic [7:0] m_src [2];
    logic [7:0] m_rx  [2];

    always @(posedge clk or negedge rst_n) begin
        bit idle;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0; m_q[i] = 0; m_rx[i] = 8'h00;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                idle = !m_act[i] || (m_q[i] >= 17 * HV[i]);
                if (m_act[i]) m_q[i]++;
                if (m_act[i] && m_q[i] == 17 * HV[i]) m_rx[i] = m_src[i];
                if (idle && start_q[i]) begin
                    m_act[i] = 1'b1;
                    m_q[i]   = 0;
                    m_tx[i]  = tx_q[i];
                    m_src[i] = (i == 0 && !loop0) ? p_byte : tx_q[i];
                end
            end
        end
    end

    // {ss, sck, mosi, busy, done, rx_data[7:0]}
    function automatic logic [12:0] exp_out(int h, bit act, int q, logic [7:0] tx, logic [7:0] rx);
        logic ss, sck, mosi, busy, done;
        int   b;
        if (act && q < 17 * h) begin
            ss = 1'b0; busy = 1'b1; done = 1'b0;
            sck = ((q / h) % 2) == 1;
            b = q / (2 * h);
            if (b > 7) b = 7;
            mosi = tx[7 - b];
        end else begin
            ss = 1'b1; busy = 1'b0; sck = 1'b0; mosi = 1'b0;
            done = act && (q == 17 * h);
        end
        return {ss, sck, mosi, busy, done, rx};
    endfunction

    always @(negedge clk) if (rst_n) begin
        logic [12:0] e, a;
        for (int i = 0; i < 2; i++) begin
            e = exp_out(HV[i], m_act[i], m_q[i], m_tx[i], m_rx[i]);
            a = {ss_o[i], sck_o[i], mosi_o[i], busy_o[i], done_o[i], rx_o[i]};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL model[%0d] cyc %0d: ss/sck/mosi/busy/done=%b rx=%h, need %b rx=%h",
                         i, cyc, a[12:8], a[7:0], e[12:8], e[7:0]);
            end
        end
    end

    // ---------------- monitors ----------------
    int   busy_start [2] = '{0, 0};
    int   busy_cnt   [2] = '{0, 0};
    int   lat        [2] = '{0, 0};
    int   done_cnt   [2] = '{0, 0};
    int   done_last  [2] = '{0, 0};
    int   ss_run     [2] = '{0, 0};
    int   ss_gap     [2] = '{0, 0};
    logic busy_prev  [2] = '{1'b0, 1'b0};
    logic ss_prev    [2] = '{1'b1, 1'b1};

    always @(negedge clk) if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (busy_o[i] && !busy_prev[i]) begin
                busy_start[i] = cyc;
                busy_cnt[i]   = 0;
            end
            if (busy_o[i]) busy_cnt[i]++;
            if (done_o[i]) begin
                done_cnt[i]++;
                done_last[i] = cyc;
                lat[i] = cyc - busy_start[i] + 1;
            end
            if (ss_o[i]) ss_run[i]++;
            else begin
                if (ss_prev[i]) ss_gap[i] = ss_run[i];
                ss_run[i] = 0;
            end
            busy_prev[i] = busy_o[i];
            ss_prev[i]   = ss_o[i];
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), need %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_done(input int i, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_o[i] && n < budget);
        if (!done_o[i]) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout[%0d]: no done within %0d cycles", i, budget);
        end
        #1;
    endtask

    task automatic launch(input int i, input logic [7:0] b);
        start_q[i] = 1'b1;
        tx_q[i]    = b;
        @(negedge clk);
        start_q[i] = 1'b0;
        tx_q[i]    = 8'($urandom);
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int d0, n;
        logic [7:0] r0;
        start_q[0] = 1'b0; start_q[1] = 1'b0;
        tx_q[0] = 8'h00;   tx_q[1] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst ss",   ss_o[0],   1);
        check("rst sck",  sck_o[0],  0);
        check("rst mosi", mosi_o[0], 0);
        check("rst busy", busy_o[0], 0);
        check("rst done", done_o[0], 0);
        check("rst rx",   rx_o[0],   0);
        check("rst ss2",  ss_o[1],   1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // loopback A5
        launch(0, 8'hA5);
        wait_done(0, 200);
        check("A5 latency", lat[0], 69);
        check("A5 rx", rx_o[0], 8'hA5);
        check("A5 sck rises", p_rises, 8);
        check("A5 mosi bits", p_cap, 8'hA5);

        // peripheral returns 3C while C3 is sent
        loop0 = 1'b0; p_byte = 8'h3C;
        launch(0, 8'hC3);
        wait_done(0, 200);
        check("C3 periph capture", p_cap, 8'hC3);
        check("C3 rx", rx_o[0], 8'h3C);
        check("C3 busy cycles", busy_cnt[0], 68);
        loop0 = 1'b1;

        // start held high: 01 then 80 back-to-back
        start_q[0] = 1'b1; tx_q[0] = 8'h01;
        n = 0;
        do begin @(negedge clk); n++; end while (!busy_o[0] && n < 10);
        tx_q[0] = 8'h80;
        wait_done(0, 200);
        d0 = done_last[0];
        check("b2b first rx", rx_o[0], 8'h01);
        @(negedge clk);
        start_q[0] = 1'b0;
        wait_done(0, 200);
        check("b2b done spacing", done_last[0] - d0, 69);
        check("b2b ss gap", ss_gap[0], 1);
        check("b2b second rx", rx_o[0], 8'h80);

        // start pulsed mid-transfer is ignored
        d0 = done_cnt[0];
        launch(0, 8'h96);
        repeat (18) @(negedge clk);
        start_q[0] = 1'b1; tx_q[0] = 8'h3F;
        @(negedge clk);
        start_q[0] = 1'b0;
        wait_done(0, 200);
        repeat (100) @(negedge clk);
        #1;
        check("ignored start done count", done_cnt[0] - d0, 1);
        check("ignored start mosi", p_cap, 8'h96);
        check("ignored start rx", rx_o[0], 8'h96);

        // asynchronous reset mid-transfer
        launch(0, 8'h77);
        repeat (28) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst ss",   ss_o[0],   1);
        check("arst sck",  sck_o[0],  0);
        check("arst mosi", mosi_o[0], 0);
        check("arst busy", busy_o[0], 0);
        check("arst rx",   rx_o[0],   0);
        d0 = done_cnt[0];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        #1;
        check("arst no done", done_cnt[0] - d0, 0);
        launch(0, 8'h5A);
        wait_done(0, 200);
        check("post-reset rx", rx_o[0], 8'h5A);

        // CLK_DIV=2 loopback
        launch(1, 8'hFF);
        wait_done(1, 100);
        check("div2 FF latency", lat[1], 35);
        check("div2 FF rx", rx_o[1], 8'hFF);
        launch(1, 8'h00);
        wait_done(1, 100);
        check("div2 00 latency", lat[1], 35);
        check("div2 00 rx", rx_o[1], 8'h00);

        // random free-running traffic on both instances
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy_o[0] && !done_o[0]) begin
                loop0  = 1'($urandom);
                p_byte = 8'($urandom);
            end
            start_q[0] = ($urandom_range(0, 15) == 0);
            start_q[1] = ($urandom_range(0, 7) == 0);
            tx_q[0]    = 8'($urandom);
            tx_q[1]    = 8'($urandom);
        end
        @(negedge clk);
        start_q[0] = 1'b0; start_q[1] = 1'b0;
        repeat (200) @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/spi_controller.md
# spi_controller

SPI controller (master) that initiates single-byte, full-duplex transfers to an SPI peripheral such as the `spi` block. It generates `sck` and `ss` and shifts `tx_data` out on `mosi` MSB-first while capturing `miso` into `rx_data`. It uses SPI mode 0 (CPOL=0, CPHA=0) with one byte per `ss` assertion. It sits between on-chip logic that issues `start` / `tx_data` and the external 4-wire SPI bus.

## Interface
- `CLK_DIV`, default 4: `sck` half-period in `clk` cycles. Legal range is ≥2. `sck` frequency is clk/(2·CLK_DIV).
- `clk`  input  1  system clock. All logic is on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  transfer request. Sampled only while `busy`=0.
- `tx_data`  input  8  byte to send. Captured in the cycle `start` is accepted.
- `busy`  output  1  high from the cycle after acceptance until the cycle `done` pulses.
- `done`  output  1  one-cycle pulse when the transfer completes and `rx_data` is valid.
- `rx_data`  output  8  last received byte. Holds its value until the next `done`.
- `sck`  output  1  SPI clock. Idles low.
- `ss`  output  1  SPI select, active-low. Idles high.
- `mosi`  output  1  controller data out. Driven 0 while `ss`=1.
- `miso`  input  1  peripheral data in. Tri-stated by the peripheral while `ss`=1.

## Operation
- FSM states: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE:
  - `ss`=1, `sck`=0, `mosi`=0, `busy`=0.
  - `start`=1 latches `tx_data` into the tx shift register and moves to SETUP.
- SETUP:
  - `ss`=0 and `mosi`=tx bit 7.
  - Lasts CLK_DIV cycles, then moves to XFER.
- XFER (16 half-periods of CLK_DIV cycles each):
  - `sck` toggles at each half-period boundary.
  - On each `sck` rising edge, `miso` is sampled into the rx shift register LSB-side, shifting left.
  - On each `sck` falling edge except the 8th, the tx register shifts left and `mosi` presents the next bit.
  - A 4-bit edge counter plus a divider counter of width clog2(CLK_DIV) track position.
- HOLD:
  - Entered at the 8th `sck` falling edge. `sck`=0, `ss`=0, `mosi` holds bit 0.
  - Lasts CLK_DIV cycles.
  - On exit: `ss`→1, `mosi`→0, `rx_data`←rx shift register, `done`=1 for one cycle, `busy`→0, state→IDLE.
- `start` while `busy`=1 is ignored and not queued.
- `tx_data` changes after acceptance have no effect on the current transfer.
- Reset (asynchronous, any state, including mid-transfer):
  - Outputs go to `ss`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=8'h00.
  - Shift registers and counters clear and the state returns to IDLE.
  - No `done` pulse is produced for an aborted transfer.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Timing
- Cycle 0 is the `clk` edge where `start` is accepted. Let H = CLK_DIV.
- Cycle 1: `ss`=0, `busy`=1, `mosi`=tx[7].
- `sck` rises at cycles 1+H, 1+3H, …, 1+15H. `miso` is sampled at these same edges.
- `sck` falls at cycles 1+2H, …, 1+16H. `mosi` updates at the falls at 1+2H … 1+14H.
- Cycle 1+17H: `ss`=1, `done`=1, `busy`=0, `rx_data` valid. With H=4 this is cycle 69.
- If `start` is high in cycle 1+17H, it is accepted in that cycle, and `ss` falls again at 2+17H. This gives a minimum `ss`-high gap of 1 cycle. Back-to-back period is 1+17H cycles.
- The peripheral sees mosi setup = H cycles before each `sck` rise and hold = H cycles after it.

## Test plan
- Loopback with `miso` tied to `mosi`, CLK_DIV=4, `tx_data`=8'hA5:
  - `rx_data`=8'hA5 with `done` at cycle 69.
  - Exactly 8 `sck` rising edges while `ss`=0.
  - `mosi` bit sequence 1,0,1,0,0,1,0,1.
- Behavioral mode-0 peripheral returning 8'h3C, `tx_data`=8'hC3:
  - Peripheral captures 8'hC3.
  - `rx_data`=8'h3C.
  - `busy` high for exactly 68 cycles.
- `start` held high continuously with `tx_data` 8'h01 then 8'h80:
  - Two transfers separated by exactly 1 cycle of `ss`=1.
  - Two `done` pulses 69 cycles apart.
- `start` pulsed at cycle 20 of an active transfer with a different `tx_data`:
  - Ignored; only one `done`.
  - The first byte is transmitted unchanged.
- `rst_n` asserted at cycle 30 of a transfer (asynchronously, mid-`clk`):
  - `ss`=1, `sck`=0, `mosi`=0, `busy`=0, `rx_data`=8'h00 immediately.
  - No `done`.
  - A new 8'h5A transfer after release completes correctly.
- CLK_DIV=2, loopback 8'hFF then 8'h00:
  - `done` at cycle 35 for each transfer.
  - `rx_data`=8'hFF, then 8'h00.
